// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - default parameter values
//   - 6-bit state codes (legacy numeric encoding, visible on the state port)
//   - instruction class codes (ir[27:25])
//   - instruction field bundle and wait-state helper
package ctrl_pkg;

  localparam int unsigned STATE_W_DEF     = 7;
  localparam int unsigned IR_W_DEF        = 32;
  localparam int unsigned MOC_TIMEOUT_DEF = 16;

  localparam int unsigned CODE_W = 6;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t S_RST    = 6'd0;
  localparam code_t S_F1     = 6'd1;
  localparam code_t S_F2     = 6'd2;
  localparam code_t S_FWAIT  = 6'd3;
  localparam code_t S_DECODE = 6'd4;
  localparam code_t S_DPI    = 6'd5;
  localparam code_t S_DPI2   = 6'd6;
  localparam code_t S_DPR    = 6'd7;
  localparam code_t S_BR     = 6'd8;
  localparam code_t S_BL     = 6'd10;
  localparam code_t S_LSADDR = 6'd33;
  localparam code_t S_LDREQ  = 6'd34;
  localparam code_t S_LDWAIT = 6'd35;
  localparam code_t S_LDWB   = 6'd36;
  localparam code_t S_WBBASE = 6'd38;
  localparam code_t S_STREQ  = 6'd41;
  localparam code_t S_STWAIT = 6'd42;
  localparam code_t S_UNDEF  = 6'd61;
  localparam code_t S_ABORT  = 6'd62;
  localparam code_t S_IRQ    = 6'd63;

  localparam logic [2:0] CLS_DPR = 3'b000;
  localparam logic [2:0] CLS_DPI = 3'b001;
  localparam logic [2:0] CLS_LS0 = 3'b010;
  localparam logic [2:0] CLS_LS1 = 3'b011;
  localparam logic [2:0] CLS_BR  = 3'b101;

  // Decoded instruction fields the sequencer cares about.
  typedef struct packed {
    logic [2:0] cls;  // ir[27:25]
    logic       p;    // ir[24] pre-index / branch-with-link
    logic       w;    // ir[21] write-back
    logic       l;    // ir[20] load
  } ir_fields_t;

  function automatic logic is_wait(input code_t c);
    return (c == S_FWAIT) || (c == S_LDWAIT) || (c == S_STWAIT);
  endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// ctrl_next_state: purely combinational next-state function of the sequencer.
//   state : current registered state (STATE_W bits)
//   f     : decoded instruction fields
//   moc   : memory operation complete
//   cond  : condition pass (used in DECODE only)
//   irq   : interrupt request (used in F1 only)
//   tmo   : wait counter has reached its last allowed cycle
//   nxt   : next state
module ctrl_next_state
  import ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF
) (
  input  logic [STATE_W-1:0] state,
  input  ir_fields_t         f,
  input  logic               moc,
  input  logic               cond,
  input  logic               irq,
  input  logic               tmo,
  output logic [STATE_W-1:0] nxt
);

  code_t code;
  logic  in_range;
  logic  wb;
  code_t n;

  always_comb begin
    code     = state[CODE_W-1:0];
    // Any set bit above the 6-bit code is an unlisted state.
    in_range = ((state >> CODE_W) == '0);
    wb       = ~f.p | f.w;
    n        = S_F1;
    case (code)
      S_RST:    n = S_F1;
      S_F1:     n = irq ? S_IRQ : S_F2;
      S_IRQ:    n = S_F1;
      S_F2:     n = S_FWAIT;
      S_FWAIT:  n = moc ? S_DECODE : (tmo ? S_ABORT : S_FWAIT);
      S_DECODE: begin
        if (!cond) begin
          n = S_F1;
        end else begin
          case (f.cls)
            CLS_DPR:          n = S_DPR;
            CLS_DPI:          n = S_DPI;
            CLS_BR:           n = f.p ? S_BL : S_BR;
            CLS_LS0, CLS_LS1: n = S_LSADDR;
            default:          n = S_UNDEF;
          endcase
        end
      end
      S_DPI:    n = S_DPI2;
      S_DPI2:   n = S_F1;
      S_DPR:    n = S_F1;
      S_BR:     n = S_F1;
      S_BL:     n = S_F1;
      S_LSADDR: n = f.l ? S_LDREQ : S_STREQ;
      S_LDREQ:  n = S_LDWAIT;
      S_LDWAIT: n = moc ? S_LDWB : (tmo ? S_ABORT : S_LDWAIT);
      S_LDWB:   n = wb ? S_WBBASE : S_F1;
      S_WBBASE: n = S_F1;
      S_STREQ:  n = S_STWAIT;
      S_STWAIT: n = moc ? (wb ? S_WBBASE : S_F1) : (tmo ? S_ABORT : S_STWAIT);
      S_UNDEF:  n = S_F1;
      S_ABORT:  n = S_F1;
      default:  n = S_F1;
    endcase
    if (!in_range) n = S_F1;
  end

  assign nxt = STATE_W'(n);

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction control sequencer (Moore FSM).
//   CLK     : clock, all state changes on posedge
//   CLR     : asynchronous active-high reset
//   ir      : current instruction
//   moc     : memory operation complete
//   cond    : condition-code pass
//   irq     : level interrupt request
//   state   : registered state code
//   mfa     : memory function active
//   mem_rw  : 1 = read, 0 = write (meaningful while mfa=1)
//   abort   : high while in ABORT (memory timeout)
//   undef   : high while in UNDEF (undefined class)
//   irq_ack : high while in IRQ
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned IR_W        = IR_W_DEF,
  parameter int unsigned MOC_TIMEOUT = MOC_TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [IR_W-1:0]    ir,
  input  logic               moc,
  input  logic               cond,
  input  logic               irq,
  output logic [STATE_W-1:0] state,
  output logic               mfa,
  output logic               mem_rw,
  output logic               abort,
  output logic               undef,
  output logic               irq_ack
);

  localparam int unsigned CNT_W    = (MOC_TIMEOUT == 0) ? 1 : $clog2(MOC_TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (MOC_TIMEOUT == 0) ? 0 : MOC_TIMEOUT - 1;

  logic [STATE_W-1:0] nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tmo;
  ir_fields_t         f;
  code_t              code;
  logic               in_range;
  logic               unused_ir;

  assign f.cls = ir[27:25];
  assign f.p   = ir[24];
  assign f.w   = ir[21];
  assign f.l   = ir[20];
  assign unused_ir = ^ir;

  assign tmo = (MOC_TIMEOUT != 0) && (cnt == CNT_W'(TMO_LAST));

  ctrl_next_state #(
    .STATE_W (STATE_W)
  ) u_next (
    .state (state),
    .f     (f),
    .moc   (moc),
    .cond  (cond),
    .irq   (irq),
    .tmo   (tmo),
    .nxt   (nxt)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= '0;
    else     state <= nxt;
  end

  // No wait state is ever entered from another wait state, so holding the
  // counter at zero outside wait states is the same as clearing it on entry.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt <= '0;
    end else if (!(in_range && is_wait(code))) begin
      cnt <= '0;
    end else if (!moc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output decode from the registered state only. mem_rw is held low in RST
  // so every single-bit output is 0 while reset is applied.
  always_comb begin
    code     = state[CODE_W-1:0];
    in_range = ((state >> CODE_W) == '0);
    mfa      = 1'b0;
    mem_rw   = 1'b1;
    abort    = 1'b0;
    undef    = 1'b0;
    irq_ack  = 1'b0;
    if (in_range) begin
      case (code)
        S_RST:                      mem_rw = 1'b0;
        S_F2, S_FWAIT:              mfa    = 1'b1;
        S_LDREQ, S_LDWAIT:          mfa    = 1'b1;
        S_STREQ, S_STWAIT: begin
          mfa    = 1'b1;
          mem_rw = 1'b0;
        end
        S_ABORT:                    abort   = 1'b1;
        S_UNDEF:                    undef   = 1'b1;
        S_IRQ:                      irq_ack = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
